// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit RISC CPU: bus widths, opcode codes,
// controller state encoding and the ALU-opcode classifier.
// No ports; imported by the controller, its decoder, the ALU and benches.
package risc_pkg;

   localparam int unsigned DATA_WIDTH   = 8;
   localparam int unsigned ADDR_WIDTH   = 5;
   localparam int unsigned OPCODE_WIDTH = DATA_WIDTH - ADDR_WIDTH;
   localparam int unsigned PHASE_WIDTH  = 3;
   localparam int unsigned STATE_WIDTH  = PHASE_WIDTH + 1;

   localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 3'b000;
   localparam logic [OPCODE_WIDTH-1:0] OP_SKZ = 3'b001;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 3'b010;
   localparam logic [OPCODE_WIDTH-1:0] OP_AND = 3'b011;
   localparam logic [OPCODE_WIDTH-1:0] OP_XOR = 3'b100;
   localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 3'b101;
   localparam logic [OPCODE_WIDTH-1:0] OP_STO = 3'b110;
   localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 3'b111;

   // State = {halted flag, phase}. HALTED carries phase 4 in its low bits
   // so the phase output reads 4 while halted without extra muxing.
   localparam logic [STATE_WIDTH-1:0] ST_INST_ADDR  = 4'b0000;
   localparam logic [STATE_WIDTH-1:0] ST_INST_FETCH = 4'b0001;
   localparam logic [STATE_WIDTH-1:0] ST_INST_LOAD  = 4'b0010;
   localparam logic [STATE_WIDTH-1:0] ST_IDLE       = 4'b0011;
   localparam logic [STATE_WIDTH-1:0] ST_OP_ADDR    = 4'b0100;
   localparam logic [STATE_WIDTH-1:0] ST_OP_FETCH   = 4'b0101;
   localparam logic [STATE_WIDTH-1:0] ST_ALU_OP     = 4'b0110;
   localparam logic [STATE_WIDTH-1:0] ST_STORE      = 4'b0111;
   localparam logic [STATE_WIDTH-1:0] ST_HALTED     = 4'b1100;

   // Opcodes whose operand is read from memory and loaded into the accumulator.
   function automatic logic is_aluop(input logic [OPCODE_WIDTH-1:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
   endfunction

endpackage

// File: rtl/risc_controller_if.sv
// Controller <-> datapath bundle.
// master (controller): inputs opcode, zero; outputs sel, rd, ld_ir, inc_pc,
//   halt, ld_pc, data_e, ld_ac, wr, phase.
// slave (datapath/bench): the mirror image.
interface risc_controller_if;
   import risc_pkg::*;

   logic [OPCODE_WIDTH-1:0] opcode;
   logic                    zero;
   logic                    sel;
   logic                    rd;
   logic                    ld_ir;
   logic                    inc_pc;
   logic                    halt;
   logic                    ld_pc;
   logic                    data_e;
   logic                    ld_ac;
   logic                    wr;
   logic [PHASE_WIDTH-1:0]  phase;

   modport master (
      input  opcode, zero,
      output sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, phase
   );

   modport slave (
      output opcode, zero,
      input  sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, phase
   );

endinterface

// File: rtl/risc_ctrl_decode.sv
// Combinational strobe decoder for the RISC controller.
// Inputs : i_state (controller state), i_opcode (IR opcode), i_zero (ALU is_zero).
// Outputs: o_sel, o_rd, o_ld_ir, o_inc_pc, o_halt, o_ld_pc, o_data_e, o_ld_ac, o_wr.
module risc_ctrl_decode
   import risc_pkg::*;
(
   input  logic [STATE_WIDTH-1:0]  i_state,
   input  logic [OPCODE_WIDTH-1:0] i_opcode,
   input  logic                    i_zero,
   output logic                    o_sel,
   output logic                    o_rd,
   output logic                    o_ld_ir,
   output logic                    o_inc_pc,
   output logic                    o_halt,
   output logic                    o_ld_pc,
   output logic                    o_data_e,
   output logic                    o_ld_ac,
   output logic                    o_wr
);

   logic w_aluop;
   logic w_is_hlt;
   logic w_is_skz;
   logic w_is_sto;
   logic w_is_jmp;

   assign w_aluop  = is_aluop(i_opcode);
   assign w_is_hlt = (i_opcode == OP_HLT);
   assign w_is_skz = (i_opcode == OP_SKZ);
   assign w_is_sto = (i_opcode == OP_STO);
   assign w_is_jmp = (i_opcode == OP_JMP);

   // Opcode terms only appear in the arms for phases 4..7, so fetch-phase
   // strobes never depend on a stale or unknown IR.
   always_comb begin
      o_sel    = 1'b0;
      o_rd     = 1'b0;
      o_ld_ir  = 1'b0;
      o_inc_pc = 1'b0;
      o_halt   = 1'b0;
      o_ld_pc  = 1'b0;
      o_data_e = 1'b0;
      o_ld_ac  = 1'b0;
      o_wr     = 1'b0;
      case (i_state)
         ST_INST_ADDR: begin
            o_sel = 1'b1;
         end
         ST_INST_FETCH: begin
            o_sel = 1'b1;
            o_rd  = 1'b1;
         end
         ST_INST_LOAD, ST_IDLE: begin
            o_sel   = 1'b1;
            o_rd    = 1'b1;
            o_ld_ir = 1'b1;
         end
         ST_OP_ADDR: begin
            o_inc_pc = 1'b1;
            o_halt   = w_is_hlt;
         end
         ST_OP_FETCH: begin
            o_rd = w_aluop;
         end
         ST_ALU_OP: begin
            o_rd     = w_aluop;
            o_inc_pc = w_is_skz & i_zero;
            o_ld_pc  = w_is_jmp;
            o_data_e = w_is_sto;
         end
         ST_STORE: begin
            o_rd     = w_aluop;
            o_ld_ac  = w_aluop;
            o_ld_pc  = w_is_jmp;
            o_inc_pc = w_is_jmp;
            o_wr     = w_is_sto;
            o_data_e = w_is_sto;
         end
         ST_HALTED: begin
            o_halt = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/risc_controller.sv
// 8-phase instruction sequencer for the 8-bit RISC CPU.
// Ports: clk (rising-edge clock), rst_n (synchronous active-low reset),
//   bus (risc_controller_if.master: opcode/zero in, control strobes and
//   phase out). Holds the state register and next-state logic; strobe
//   decode lives in risc_ctrl_decode.
module risc_controller
   import risc_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   risc_controller_if.master         bus
);

   logic [STATE_WIDTH-1:0] r_state;
   logic [STATE_WIDTH-1:0] w_state_nxt;

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_HALTED) begin
         w_state_nxt = ST_HALTED;
      end else if ((r_state == ST_OP_ADDR) && (bus.opcode == OP_HLT)) begin
         w_state_nxt = ST_HALTED;
      end else begin
         // Phase counter wraps 7 -> 0 naturally in PHASE_WIDTH bits.
         w_state_nxt = {1'b0, r_state[PHASE_WIDTH-1:0] + 3'd1};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_INST_ADDR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   assign bus.phase = r_state[PHASE_WIDTH-1:0];

   risc_ctrl_decode u_decode (
      .i_state  (r_state),
      .i_opcode (bus.opcode),
      .i_zero   (bus.zero),
      .o_sel    (bus.sel),
      .o_rd     (bus.rd),
      .o_ld_ir  (bus.ld_ir),
      .o_inc_pc (bus.inc_pc),
      .o_halt   (bus.halt),
      .o_ld_pc  (bus.ld_pc),
      .o_data_e (bus.data_e),
      .o_ld_ac  (bus.ld_ac),
      .o_wr     (bus.wr)
   );

endmodule

// File: tb/tb_risc_controller.sv
// Directed self-checking bench for risc_controller.
// Strobe vector order: {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr}.
module tb_risc_controller;
   import risc_pkg::*;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   risc_controller_if ifc ();

   risc_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   logic [8:0] w_obs;
   assign w_obs = {ifc.sel, ifc.rd, ifc.ld_ir, ifc.inc_pc, ifc.halt,
                   ifc.ld_pc, ifc.data_e, ifc.ld_ac, ifc.wr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      ifc.opcode = 3'bxxx;
      ifc.zero   = 1'bx;
      for (int i = 0; i < 2; i++) begin
         step();
         total++;
         if (ifc.phase !== 3'd0) begin
            bad++;
            $display("FAIL reset_phase edge%0d got=%0d exp=0", i, ifc.phase);
         end
         total++;
         if (w_obs !== 9'b100000000) begin
            bad++;
            $display("FAIL reset_strobes edge%0d got=%b exp=100000000", i, w_obs);
         end
      end
      rst_n = 1'b1;
   endtask

   // Unknown opcode during phases 0..2 must not disturb the fetch strobes.
   task automatic test_add();
      logic [8:0] exp [8];
      exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
              9'b000100000, 9'b010000000, 9'b010000000, 9'b010000010};
      ifc.opcode = 3'bxxx;
      ifc.zero   = 1'b0;
      for (int p = 0; p < 8; p++) begin
         if (p == 3) ifc.opcode = OP_ADD;
         total++;
         if (ifc.phase !== 3'(p)) begin
            bad++;
            $display("FAIL add_phase p%0d got=%0d exp=%0d", p, ifc.phase, p);
         end
         total++;
         if (w_obs !== exp[p]) begin
            bad++;
            $display("FAIL add_strobes p%0d got=%b exp=%b", p, w_obs, exp[p]);
         end
         step();
      end
      total++;
      if (ifc.phase !== 3'd0) begin
         bad++;
         $display("FAIL add_wrap got=%0d exp=0", ifc.phase);
      end
   endtask

   task automatic test_skz(input logic z);
      logic [8:0] exp [8];
      exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
              9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000};
      if (z) exp[6] = 9'b000100000;
      ifc.opcode = OP_SKZ;
      ifc.zero   = z;
      for (int p = 0; p < 8; p++) begin
         total++;
         if (w_obs !== exp[p] || ifc.phase !== 3'(p)) begin
            bad++;
            $display("FAIL skz_z%0b p%0d got=%b/%0d exp=%b/%0d", z, p, w_obs, ifc.phase, exp[p], p);
         end
         step();
      end
   endtask

   task automatic test_sto();
      logic [8:0] exp [8];
      exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
              9'b000100000, 9'b000000000, 9'b000000100, 9'b000000101};
      ifc.opcode = OP_STO;
      ifc.zero   = 1'b1;
      for (int p = 0; p < 8; p++) begin
         total++;
         if (w_obs !== exp[p] || ifc.phase !== 3'(p)) begin
            bad++;
            $display("FAIL sto p%0d got=%b/%0d exp=%b/%0d", p, w_obs, ifc.phase, exp[p], p);
         end
         step();
      end
   endtask

   task automatic test_jmp();
      logic [8:0] exp [8];
      exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
              9'b000100000, 9'b000000000, 9'b000001000, 9'b000101000};
      ifc.opcode = OP_JMP;
      ifc.zero   = 1'b0;
      for (int p = 0; p < 8; p++) begin
         total++;
         if (w_obs !== exp[p] || ifc.phase !== 3'(p)) begin
            bad++;
            $display("FAIL jmp p%0d got=%b/%0d exp=%b/%0d", p, w_obs, ifc.phase, exp[p], p);
         end
         step();
      end
   endtask

   task automatic test_halt();
      logic [8:0] exp [5];
      exp = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
              9'b000110000};
      ifc.opcode = OP_HLT;
      ifc.zero   = 1'b0;
      for (int p = 0; p < 5; p++) begin
         total++;
         if (w_obs !== exp[p] || ifc.phase !== 3'(p)) begin
            bad++;
            $display("FAIL hlt p%0d got=%b/%0d exp=%b/%0d", p, w_obs, ifc.phase, exp[p], p);
         end
         step();
      end
      // Inputs wiggle while halted; nothing may react.
      for (int c = 0; c < 20; c++) begin
         ifc.opcode = 3'($urandom_range(0, 7));
         ifc.zero   = 1'($urandom_range(0, 1));
         #1;
         total++;
         if (w_obs !== 9'b000010000 || ifc.phase !== 3'd4) begin
            bad++;
            $display("FAIL halted c%0d got=%b/%0d exp=000010000/4", c, w_obs, ifc.phase);
         end
         step();
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      total++;
      if (w_obs !== 9'b100000000 || ifc.phase !== 3'd0) begin
         bad++;
         $display("FAIL halt_reset got=%b/%0d exp=100000000/0", w_obs, ifc.phase);
      end
   endtask

   task automatic test_reset_mid();
      ifc.opcode = OP_ADD;
      ifc.zero   = 1'b0;
      for (int i = 0; i < 6; i++) step();
      total++;
      if (ifc.phase !== 3'd6 || w_obs !== 9'b010000000) begin
         bad++;
         $display("FAIL mid_pre got=%b/%0d exp=010000000/6", w_obs, ifc.phase);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      total++;
      if (ifc.phase !== 3'd0 || w_obs !== 9'b100000000) begin
         bad++;
         $display("FAIL mid_reset got=%b/%0d exp=100000000/0", w_obs, ifc.phase);
      end
      step();
      total++;
      if (ifc.phase !== 3'd1 || w_obs !== 9'b110000000) begin
         bad++;
         $display("FAIL mid_release got=%b/%0d exp=110000000/1", w_obs, ifc.phase);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      ifc.opcode = OP_HLT;
      ifc.zero   = 1'b0;
      #2;
      test_reset();
      test_add();
      test_skz(1'b1);
      test_skz(1'b0);
      test_sto();
      test_jmp();
      test_halt();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/risc_controller.md
Name: risc_controller

Overview:
Instruction sequencer for the 8-bit RISC CPU. It steps every instruction through a fixed 8-phase fetch/execute cycle and decodes the 3-bit opcode from the instruction register into the control strobes for the PC, memory, IR, ALU, accumulator and data bus. It sits directly upstream of the ALU and accumulator: it decides when the ALU result is loaded and when `is_zero` is sampled for SKZ.

Parameters:
OPCODE_WIDTH, 3, opcode width; equals `DATA_WIDTH - `ADDR_WIDTH.
PHASE_WIDTH, 3, width of the phase counter (8 phases).

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  synchronous, active-low reset; sampled on the rising clk edge
opcode  input  OPCODE_WIDTH  IR opcode field; valid from phase IDLE onward
zero  input  1  ALU `is_zero` (accumulator == 0)
sel  output  1  1 = PC drives the address bus, 0 = IR operand address does
rd  output  1  memory read
ld_ir  output  1  load instruction register
inc_pc  output  1  PC increment
halt  output  1  CPU halted
ld_pc  output  1  load PC from IR address (JMP)
data_e  output  1  drive accumulator onto the data bus
ld_ac  output  1  load accumulator from the ALU result
wr  output  1  memory write
phase  output  PHASE_WIDTH  current phase (debug / bench sync)

Behaviour:
- Phases, in order: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE. The sequence wraps 7 -> 0.
- There is one extra state, HALTED, encoded outside the phase counter.
- Opcodes: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- ALUOP = ADD | AND | XOR | LDA.
- Outputs are combinational decode of (state, opcode, zero). They are not registered. Any output not listed for a phase is 0.
- INST_ADDR: sel.
- INST_FETCH: sel, rd.
- INST_LOAD: sel, rd, ld_ir.
- IDLE: sel, rd, ld_ir.
- OP_ADDR: inc_pc. If opcode == HLT, also halt, and the next state is HALTED instead of OP_FETCH.
- OP_FETCH: rd = ALUOP.
- ALU_OP:
  - rd = ALUOP
  - inc_pc = (SKZ & zero)
  - ld_pc = JMP
  - data_e = STO
- STORE:
  - rd = ALUOP
  - ld_ac = ALUOP
  - ld_pc = JMP
  - inc_pc = JMP
  - wr = STO
  - data_e = STO
- HALTED: halt = 1, all other outputs 0, phase holds at 4. The controller stays in HALTED until reset; opcode and zero are ignored.
- Reset: when rst_n = 0 at a rising edge, the next state is INST_ADDR regardless of the current state, including mid-instruction and HALTED. After that edge: phase = 0, sel = 1, all other outputs 0.
- Reset timing: the first rising edge with rst_n = 1 advances to INST_FETCH. Reset has no asynchronous effect.
- zero is only used in ALU_OP and only when opcode = SKZ. The skip is a second PC increment, so SKZ with zero = 1 advances the PC by 2 in total.
- Latency: exactly 8 clocks per non-HLT instruction. HLT reaches HALTED 5 clocks after INST_ADDR.
- opcode values X/Z outside IDLE..STORE must not affect outputs. Phases 0–2 are opcode-independent.

Decomposition:
- Shared package risc_pkg holds:
  - DATA_WIDTH = 8 and ADDR_WIDTH = 5
  - opcode localparams HLT..JMP
  - the phase encoding (INST_ADDR..STORE)
  - the HALTED state code
- The ALU and the bench import the same opcode constants.
- One combinational sub-module, risc_ctrl_decode, maps (state, opcode, zero) to the nine strobes. risc_controller holds only the state register and next-state logic.

Test Plan:
- Reset held for 2 clocks, then released: phase = 0, sel = 1, other strobes 0. Phase sequence then runs 1,2,3,4,5,6,7,0 on consecutive edges.
- opcode = ADD (010), zero = 0, one full cycle:
  - rd = 1 in phases 5–7
  - ld_ac = 1 only in phase 7
  - inc_pc = 1 only in phase 4
  - wr, data_e, ld_pc = 0 throughout
- opcode = SKZ (001):
  - with zero = 1: inc_pc pulses in phase 4 and phase 6 (two pulses per instruction)
  - with zero = 0: only the phase-4 pulse occurs
- opcode = STO (110): data_e = 1 in phases 6–7, wr = 1 only in phase 7, rd = 0 and ld_ac = 0 in phases 5–7.
- opcode = JMP (111): ld_pc = 1 in phases 6–7, inc_pc = 1 in phase 4 and phase 7.
- opcode = HLT (000): halt = 1 from phase 4, then the controller stays in HALTED for 20 clocks with phase = 4 and all other strobes 0. Applying rst_n = 0 for one edge returns phase = 0, sel = 1, halt = 0. Reset asserted mid-instruction in phase 6 also returns to phase 0 on that edge.
